// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants for the nibble-serial adder: nibble width and FSM state codes.
package nibble_adder_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             busy;

    modport master (
        output in_valid, a, b, carry_in, out_ready,
        input  in_ready, out_valid, sum, carry_out, busy
    );

    modport slave (
        input  in_valid, a, b, carry_in, out_ready,
        output in_ready, out_valid, sum, carry_out, busy
    );
endinterface

// File: rtl/adder_4bit_behavioral.sv
// Combinational 4-bit adder with carry in/out; the serial wrapper's datapath.
module adder_4bit_behavioral (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       carry_in,
    output logic [3:0] sum,
    output logic       carry_out
);
    assign {carry_out, sum} = 5'(a) + 5'(b) + 5'(carry_in);
endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two WIDTH-bit operands one nibble per clock, LSB first, through a single
// 4-bit adder whose carry is fed back through a register.
module nibble_serial_adder
    import nibble_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    nibble_serial_adder_if.slave  io
);
    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    generate
        if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    logic [1:0]          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0]    a_sr_q, a_sr_d;
    logic [WIDTH-1:0]    b_sr_q, b_sr_d;
    logic [WIDTH-1:0]    sum_sr_q, sum_sr_d;
    logic                carry_q, carry_d;
    logic [WIDTH-1:0]    sum_q, sum_d;
    logic                cout_q, cout_d;

    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;
    logic [WIDTH+3:0]    sum_shift;
    logic                last_nib;

    adder_4bit_behavioral u_add (
        .a         (a_sr_q[NIBBLE_W-1:0]),
        .b         (b_sr_q[NIBBLE_W-1:0]),
        .carry_in  (carry_q),
        .sum       (nib_sum),
        .carry_out (nib_cout)
    );

    // New nibble enters at the top so the LSB nibble ends up at the bottom after NIBBLES shifts.
    assign sum_shift = {nib_sum, sum_sr_q};
    assign last_nib  = (idx_q == IDX_W'(NIBBLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (io.in_valid)  state_d = ST_RUN;
            ST_RUN:  if (last_nib)     state_d = ST_DONE;
            ST_DONE: if (io.out_ready) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_d    = idx_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (io.in_valid) begin
                    a_sr_d  = io.a;
                    b_sr_d  = io.b;
                    carry_d = io.carry_in;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                a_sr_d   = a_sr_q >> NIBBLE_W;
                b_sr_d   = b_sr_q >> NIBBLE_W;
                sum_sr_d = sum_shift[WIDTH+3:NIBBLE_W];
                carry_d  = nib_cout;
                idx_d    = idx_q + IDX_W'(1);
                if (last_nib) begin
                    sum_d  = sum_shift[WIDTH+3:NIBBLE_W];
                    cout_d = nib_cout;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        io.in_ready  = (state_q == ST_IDLE);
        io.out_valid = (state_q == ST_DONE);
        io.busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
        io.sum       = sum_q;
        io.carry_out = cout_q;
    end

endmodule
